mult_switch_feeder: RTL and testbench

Sequencer that drives one multiplier switch from a ready/valid word source. Per job, the first accepted word is loaded as the switch's stationary operand and the next N words are streamed against it. The block counts the products the switch returns and pulses done when the job is complete. It sits between the distribution network/source FIFO and a `mult_switch` instance, and is the transmit end of the switch's `i_valid`/`i_data`/`i_stationary` interface.

---
 rtl/mult_switch_feeder.sv | 156 +++++++++++++++
 tb/tb_mult_switch_feeder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_switch_feeder.sv
// Multiplier-switch feeder: loads a stationary word, streams N words,
// counts returned products and flags completion or drain timeout.
module mult_switch_feeder #(
  parameter int DATA_W    = 16,
  parameter int CNT_W     = 8,
  parameter int DRAIN_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_stream_len,
  input  logic              i_src_valid,
  input  logic [DATA_W-1:0] i_src_data,
  output logic              o_src_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_stationary,
  input  logic              i_ms_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int DCW = $clog2(DRAIN_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  issue_q;
  logic [CNT_W-1:0]  res_q;
  logic [DCW-1:0]    drain_q;
  logic              err_q;
  logic              ign_q;
  logic              valid_q;
  logic              stat_q;
  logic [DATA_W-1:0] data_q;

  logic              accept;
  logic              start_ok;
  logic              counting;
  logic              counted;
  logic [CNT_W-1:0]  issue_inc;
  logic [CNT_W-1:0]  res_inc;
  logic              res_full;
  logic [DCW-1:0]    drain_inc;
  logic              drain_hit;

  assign accept    = i_src_valid & o_src_ready;
  assign start_ok  = (state_q == S_IDLE) & i_start;
  assign counting  = (state_q == S_LOAD)
                   | (state_q == S_STREAM)
                   | (state_q == S_DRAIN);
  // Product counting saturates at len and skips the stale
  // product a preloaded switch emits on the stationary load.
  assign counted   = counting & i_ms_valid & ~ign_q
                   & (res_q != len_q);
  assign issue_inc = issue_q + CNT_W'(1);
  assign res_inc   = res_q + CNT_W'(counted);
  assign res_full  = (res_inc == len_q);
  assign drain_inc = counted ? '0 : drain_q + DCW'(1);
  assign drain_hit = (drain_inc == DCW'(DRAIN_MAX));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (accept)
          state_d = (len_q == '0) ? S_DONE : S_STREAM;
      end
      S_STREAM: begin
        if (accept && issue_inc == len_q)
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (res_full || drain_hit) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    o_src_ready = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    unique case (state_q)
      S_IDLE:   o_busy      = 1'b0;
      S_LOAD:   o_src_ready = 1'b1;
      S_STREAM: o_src_ready = 1'b1;
      S_DRAIN:  o_busy      = 1'b1;
      S_DONE:   o_done      = 1'b1;
      default:  o_busy      = 1'b0;
    endcase
  end

  // Issue register, counters and sticky error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      stat_q  <= 1'b0;
      data_q  <= '0;
      ign_q   <= 1'b0;
      len_q   <= '0;
      issue_q <= '0;
      res_q   <= '0;
      drain_q <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= accept;
      stat_q  <= accept & (state_q == S_LOAD);
      if (accept) data_q <= i_src_data;
      // Stale product shows up the cycle after the load issue.
      ign_q   <= valid_q & stat_q;
      if (start_ok) begin
        len_q   <= i_stream_len;
        issue_q <= '0;
        res_q   <= '0;
        drain_q <= '0;
        err_q   <= 1'b0;
      end else begin
        if (state_q == S_STREAM && accept)
          issue_q <= issue_inc;
        if (counted) res_q <= res_inc;
        if (state_q == S_DRAIN) begin
          drain_q <= drain_inc;
          if (drain_hit && !res_full) err_q <= 1'b1;
        end
      end
    end
  end

  assign o_valid      = valid_q;
  assign o_stationary = stat_q;
  assign o_data       = data_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_mult_switch_feeder.sv
// Bench for mult_switch_feeder: job table, random jobs and
// reset corner case against a cycle-level job model.
module tb_mult_switch_feeder;

  localparam int DATA_W    = 16;
  localparam int CNT_W     = 8;
  localparam int DRAIN_MAX = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_start = 1'b0;
  logic [CNT_W-1:0]  i_stream_len = '0;
  logic              i_src_valid = 1'b0;
  logic [DATA_W-1:0] i_src_data = '0;
  logic              o_src_ready;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              o_stationary;
  logic              i_ms_valid;
  logic              o_busy;
  logic              o_done;
  logic              o_err;

  logic ms_q = 1'b0;
  logic ms_stat_q = 1'b0;
  logic sw_loaded = 1'b0;
  logic kill_en = 1'b0;
  logic kill_hit = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  mult_switch_feeder #(
    .DATA_W(DATA_W),
    .CNT_W(CNT_W),
    .DRAIN_MAX(DRAIN_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_start(i_start),
    .i_stream_len(i_stream_len),
    .i_src_valid(i_src_valid),
    .i_src_data(i_src_data),
    .o_src_ready(o_src_ready),
    .o_valid(o_valid),
    .o_data(o_data),
    .o_stationary(o_stationary),
    .i_ms_valid(i_ms_valid),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  // Switch stand-in: one product per issue, one cycle later;
  // a load only returns a product if a value was already held.
  always @(posedge clk) begin
    ms_q      <= o_valid & (~o_stationary | sw_loaded);
    ms_stat_q <= o_valid & o_stationary;
    if (o_valid & o_stationary) sw_loaded <= 1'b1;
  end

  assign i_ms_valid = ms_q & ~(kill_en & kill_hit);

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int len;
    int vpat;
    bit fixed;
    bit kill;
    bit noise;
    bit exp_err;
  } vec_t;

  task automatic run_job(input int len, input int vpat,
                         input bit fixed, input bit kill,
                         input bit noise, input bit exp_err,
                         input bit prev_err);
    logic [DATA_W-1:0] src_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] fw[4];
    logic [DATA_W-1:0] w;
    int  exp_done;
    int  issued;
    int  acc_cnt;
    int  prods;
    int  run;
    bit  err_m;
    bit  prev_acc;
    bit  acc;
    bit  in_drain;
    bit  kill_pend;
    bit  finished;
    fw[0] = 16'h3F80;
    fw[1] = 16'h4000;
    fw[2] = 16'h4040;
    fw[3] = 16'h4080;
    for (int i = 0; i < len + 5; i++) begin
      w = (fixed && i < 4) ? fw[i] : DATA_W'($urandom);
      src_q.push_back(w);
      if (i < len + 1) exp_q.push_back(w);
    end
    exp_done = -1;
    issued = 0; acc_cnt = 0; prods = 0; run = 0;
    err_m = 1'b0; prev_acc = 1'b0; kill_pend = 1'b0;
    finished = 1'b0;
    @(negedge clk); #1;
    chk("err_hold", 32'(o_err), 32'(prev_err));
    chk("idle_busy", 32'(o_busy), 0);
    kill_en = kill;
    kill_hit = 1'b0;
    i_start = 1'b1;
    i_stream_len = CNT_W'(len);
    i_src_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (kill_pend) kill_hit = 1'b1;
      #1;
      if (c == 0) begin
        chk("err_clr", 32'(o_err), 0);
        chk("load_busy", 32'(o_busy), 1);
      end
      chk("valid_vs_acc", 32'(o_valid), 32'(prev_acc));
      chk("src_ready", 32'(o_src_ready),
          32'(acc_cnt < len + 1));
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_issue", 1, 0);
        end else begin
          w = exp_q.pop_front();
          chk("issue_data", 32'(o_data), 32'(w));
          chk("issue_stat", 32'(o_stationary),
              32'(issued == 0));
        end
        issued++;
        if (issued == 1 && len == 0) exp_done = c;
      end else begin
        chk("stat_idle", 32'(o_stationary), 0);
      end
      in_drain = (len > 0) && (issued == len + 1)
               && (exp_done < 0);
      if (i_ms_valid && !ms_stat_q && prods < len
          && exp_done < 0) begin
        prods++;
        if (kill) kill_pend = 1'b1;
        if (in_drain) run = 0;
        if (prods == len) exp_done = c + 1;
      end else if (in_drain) begin
        run++;
        if (run == DRAIN_MAX) begin
          exp_done = c + 1;
          err_m = 1'b1;
        end
      end
      chk("done", 32'(o_done), 32'(c == exp_done));
      if (c == exp_done) begin
        chk("err_at_done", 32'(o_err), 32'(exp_err));
        chk("model_err", 32'(err_m), 32'(exp_err));
      end
      if (exp_done >= 0 && c == exp_done + 1) begin
        chk("back_idle", 32'(o_busy), 0);
        chk("issue_count", 32'(issued), 32'(len + 1));
        finished = 1'b1;
        break;
      end
      if (noise && o_busy && c > 0) begin
        i_start = 1'($urandom);
        i_stream_len = CNT_W'($urandom);
      end else begin
        i_start = 1'b0;
      end
      case (vpat)
        0:       i_src_valid = 1'b1;
        1:       i_src_valid = (c % 2 == 0);
        default: i_src_valid = ($urandom % 3 != 0);
      endcase
      i_src_data = (src_q.size() > 0) ? src_q[0] : '0;
      acc = i_src_valid && o_src_ready;
      if (acc) begin
        void'(src_q.pop_front());
        acc_cnt++;
      end
      prev_acc = acc;
    end
    i_start = 1'b0;
    i_src_valid = 1'b0;
    kill_en = 1'b0;
    if (!finished) chk("job_timeout", 0, 1);
  endtask

  vec_t vt[7];
  bit   perr;
  int   nv;
  int   rl;

  initial begin
    vt[0] = '{len:3, vpat:0, fixed:1, kill:0, noise:0, exp_err:0};
    vt[1] = '{len:2, vpat:0, fixed:0, kill:0, noise:0, exp_err:0};
    vt[2] = '{len:4, vpat:1, fixed:0, kill:0, noise:0, exp_err:0};
    vt[3] = '{len:0, vpat:0, fixed:0, kill:0, noise:0, exp_err:0};
    vt[4] = '{len:2, vpat:0, fixed:0, kill:1, noise:0, exp_err:1};
    vt[5] = '{len:3, vpat:0, fixed:0, kill:0, noise:0, exp_err:0};
    vt[6] = '{len:5, vpat:2, fixed:0, kill:0, noise:1, exp_err:0};

    #12;
    chk("reset_outs",
        32'({o_valid, o_stationary, o_src_ready,
             o_busy, o_done, o_err, o_data}), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    perr = 1'b0;
    for (int i = 0; i < 7; i++) begin
      run_job(vt[i].len, vt[i].vpat, vt[i].fixed,
              vt[i].kill, vt[i].noise, vt[i].exp_err, perr);
      perr = vt[i].exp_err;
    end

    for (int j = 0; j < 20; j++) begin
      rl = $urandom_range(0, 10);
      run_job(rl, 2, 1'b0, 1'b0, 1'($urandom), 1'b0, 1'b0);
    end

    @(negedge clk); #1;
    i_start = 1'b1;
    i_stream_len = CNT_W'(5);
    nv = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); #1;
      if (o_valid) nv++;
      if (nv == 3) break;
      i_start = 1'b0;
      i_src_valid = 1'b1;
      i_src_data = DATA_W'($urandom);
    end
    chk("pre_rst_seen", 32'(nv), 3);
    chk("pre_rst_busy", 32'(o_busy), 1);
    rst = 1'b0;
    #1;
    chk("rst_async",
        32'({o_valid, o_stationary, o_src_ready,
             o_busy, o_done, o_err, o_data}), 0);
    i_src_valid = 1'b0;
    repeat (4) begin
      @(negedge clk); #1;
      chk("rst_no_done", 32'(o_done | o_busy), 0);
    end
    rst = 1'b1;
    run_job(3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_job(1, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
